// File: rtl/baccarat_pkg.sv
// Shared state encoding, card codes and card-to-point conversion for the baccarat deal controller.
// Latency: none (types and pure functions only); backpressure: not applicable.
package baccarat_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        DEAL_P1  = 4'd1,
        DEAL_D1  = 4'd2,
        DEAL_P2  = 4'd3,
        DEAL_D2  = 4'd4,
        DECIDE   = 4'd5,
        DEAL_P3  = 4'd6,
        DECIDE_D = 4'd7,
        DEAL_D3  = 4'd8,
        RESULT   = 4'd9
    } state_e;

    localparam logic [3:0] CARD_BLANK = 4'd0;
    localparam logic [3:0] CARD_ACE   = 4'd1;
    localparam logic [3:0] CARD_TWO   = 4'd2;
    localparam logic [3:0] CARD_THREE = 4'd3;
    localparam logic [3:0] CARD_FOUR  = 4'd4;
    localparam logic [3:0] CARD_FIVE  = 4'd5;
    localparam logic [3:0] CARD_SIX   = 4'd6;
    localparam logic [3:0] CARD_SEVEN = 4'd7;
    localparam logic [3:0] CARD_EIGHT = 4'd8;
    localparam logic [3:0] CARD_NINE  = 4'd9;
    localparam logic [3:0] CARD_TEN   = 4'd10;
    localparam logic [3:0] CARD_JACK  = 4'd11;
    localparam logic [3:0] CARD_QUEEN = 4'd12;
    localparam logic [3:0] CARD_KING  = 4'd13;

    // Tens, faces, blank and the unused codes 14/15 all count as zero points.
    function automatic logic [3:0] card_value(input logic [3:0] code);
        if (code >= CARD_ACE && code <= CARD_NINE) begin
            return code;
        end
        return CARD_BLANK;
    endfunction

endpackage

// File: rtl/baccarat_deal_ctrl_if.sv
// Controller <-> card/score datapath signal bundle.
// Latency: none (wires only); backpressure: none, strobes are fire-and-forget.
interface baccarat_deal_ctrl_if;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1;
    logic       load_pcard2;
    logic       load_pcard3;
    logic       load_dcard1;
    logic       load_dcard2;
    logic       load_dcard3;
    logic       player_win_light;
    logic       dealer_win_light;

    modport master (
        input  pscore, dscore, pcard3,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        output player_win_light, dealer_win_light
    );

    modport slave (
        output pscore, dscore, pcard3,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        input  player_win_light, dealer_win_light
    );
endinterface

// File: rtl/baccarat_deal_ctrl_bank_draw_rule.sv
// Banker third-card tableau: decides whether the banker draws given its score and the player's third-card points.
// Latency: combinational; backpressure: none.
module bank_draw_rule (
    input  logic [3:0] dscore,
    input  logic [3:0] pval,
    output logic       draw
);
    always_comb begin
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (pval != 4'd8);
            4'd4:             draw = (pval >= 4'd2) && (pval <= 4'd7);
            4'd5:             draw = (pval >= 4'd4) && (pval <= 4'd7);
            4'd6:             draw = (pval >= 4'd6) && (pval <= 4'd7);
            default:          draw = 1'b0;
        endcase
    end
endmodule

// File: rtl/baccarat_deal_ctrl.sv
// Moore FSM sequencing one baccarat round: card load strobes, third-card decisions, then win lights.
// Latency: result after 6-9 slow_clock edges from reset release; backpressure: none, RESULT holds until reset.
module baccarat_deal_ctrl
    import baccarat_pkg::*;
(
    input  logic                        slow_clock,
    input  logic                        reset,
    baccarat_deal_ctrl_if.master        bus
);
    state_e     state_q;
    state_e     state_d;
    logic [3:0] pval;
    logic       bank_draw;

    assign pval = card_value(bus.pcard3);

    bank_draw_rule u_bank_draw_rule (
        .dscore (bus.dscore),
        .pval   (pval),
        .draw   (bank_draw)
    );

    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = DEAL_P1;
            DEAL_P1: state_d = DEAL_D1;
            DEAL_D1: state_d = DEAL_P2;
            DEAL_P2: state_d = DEAL_D2;
            DEAL_D2: state_d = DECIDE;
            DECIDE: begin
                // Naturals end the round; otherwise the player acts before the banker.
                if (bus.pscore >= 4'd8 || bus.dscore >= 4'd8) begin
                    state_d = RESULT;
                end else if (bus.pscore <= 4'd5) begin
                    state_d = DEAL_P3;
                end else if (bus.dscore <= 4'd5) begin
                    state_d = DEAL_D3;
                end else begin
                    state_d = RESULT;
                end
            end
            DEAL_P3:  state_d = DECIDE_D;
            DECIDE_D: state_d = bank_draw ? DEAL_D3 : RESULT;
            DEAL_D3:  state_d = RESULT;
            RESULT:   state_d = RESULT;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.load_pcard1      = 1'b0;
        bus.load_dcard1      = 1'b0;
        bus.load_pcard2      = 1'b0;
        bus.load_dcard2      = 1'b0;
        bus.load_pcard3      = 1'b0;
        bus.load_dcard3      = 1'b0;
        bus.player_win_light = 1'b0;
        bus.dealer_win_light = 1'b0;
        case (state_q)
            DEAL_P1: bus.load_pcard1 = 1'b1;
            DEAL_D1: bus.load_dcard1 = 1'b1;
            DEAL_P2: bus.load_pcard2 = 1'b1;
            DEAL_D2: bus.load_dcard2 = 1'b1;
            DEAL_P3: bus.load_pcard3 = 1'b1;
            DEAL_D3: bus.load_dcard3 = 1'b1;
            RESULT: begin
                bus.player_win_light = (bus.pscore >= bus.dscore);
                bus.dealer_win_light = (bus.dscore >= bus.pscore);
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_baccarat_deal_ctrl.sv
// Bench for baccarat_deal_ctrl: a card datapath stand-in plus a rule-level round model checked every cycle.
module tb_baccarat_deal_ctrl;

    logic slow_clock = 1'b0;
    logic reset      = 1'b1;
    always #5 slow_clock = ~slow_clock;

    baccarat_deal_ctrl_if bus ();

    baccarat_deal_ctrl dut (
        .slow_clock (slow_clock),
        .reset      (reset),
        .bus        (bus)
    );

    typedef struct {
        logic [3:0] p1, p2, d1, d2, p3, d3;
        int         res_edge;
        logic [1:0] lights;
    } scn_t;

    localparam int NSCN = 13;
    scn_t  scn   [NSCN];
    string names [NSCN];
    scn_t  cur;
    string scn_name = "reset";

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int cv(input logic [3:0] c);
        return (c >= 4'd1 && c <= 4'd9) ? int'(c) : 0;
    endfunction

    function automatic scn_t mk(input int p1, input int p2, input int d1, input int d2,
                                input int p3, input int d3, input int re, input logic [1:0] li);
        scn_t s;
        s.p1 = 4'(p1); s.p2 = 4'(p2); s.d1 = 4'(d1); s.d2 = 4'(d2);
        s.p3 = 4'(p3); s.d3 = 4'(d3); s.res_edge = re; s.lights = li;
        return s;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%s] @%0t: got %0h want %0h", nm, scn_name, $time, act, exp);
        end
    endtask

    // {ld_p1, ld_d1, ld_p2, ld_d2, ld_p3, ld_d3, player_light, dealer_light}
    logic [7:0] dut_v;
    assign dut_v = {bus.load_pcard1, bus.load_dcard1, bus.load_pcard2, bus.load_dcard2,
                    bus.load_pcard3, bus.load_dcard3, bus.player_win_light, bus.dealer_win_light};

    // Card datapath stand-in: strobes sampled mid-cycle, cards captured on the ending edge.
    logic [3:0] pc1, pc2, pc3, dc1, dc2, dc3;
    logic [5:0] strb_s;

    always @(negedge slow_clock or posedge reset) begin
        if (reset) strb_s <= '0;
        else       strb_s <= dut_v[7:2];
    end

    always @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            pc1 <= '0; pc2 <= '0; pc3 <= '0; dc1 <= '0; dc2 <= '0; dc3 <= '0;
        end else begin
            if (strb_s[5]) pc1 <= cur.p1;
            if (strb_s[4]) dc1 <= cur.d1;
            if (strb_s[3]) pc2 <= cur.p2;
            if (strb_s[2]) dc2 <= cur.d2;
            if (strb_s[1]) pc3 <= cur.p3;
            if (strb_s[0]) dc3 <= cur.d3;
        end
    end

    assign bus.pscore = 4'((cv(pc1) + cv(pc2) + cv(pc3)) % 10);
    assign bus.dscore = 4'((cv(dc1) + cv(dc2) + cv(dc3)) % 10);
    assign bus.pcard3 = pc3;

    int n_edge;
    always @(posedge slow_clock or posedge reset) begin
        if (reset)           n_edge <= 0;
        else if (n_edge < 30) n_edge <= n_edge + 1;
    end

    // Rule-level model: bit v of bank_mask[ds] set means the banker draws against player points v.
    logic [9:0] bank_mask [10] = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h2FF, 10'h0FC,
                                   10'h0F0, 10'h0C0, 10'h000, 10'h000, 10'h000};
    logic [7:0] exp_v [16];
    int         exp_len;

    task automatic build(input scn_t s);
        int   ps, ds, pv;
        logic pdraw, ddraw;
        exp_len = 0;
        exp_v[exp_len++] = 8'h00;
        exp_v[exp_len++] = 8'h80;
        exp_v[exp_len++] = 8'h40;
        exp_v[exp_len++] = 8'h20;
        exp_v[exp_len++] = 8'h10;
        exp_v[exp_len++] = 8'h00;
        ps = (cv(s.p1) + cv(s.p2)) % 10;
        ds = (cv(s.d1) + cv(s.d2)) % 10;
        pdraw = 1'b0;
        ddraw = 1'b0;
        if (ps >= 8 || ds >= 8) begin
            pdraw = 1'b0;
        end else if (ps <= 5) begin
            pdraw = 1'b1;
            pv    = cv(s.p3);
            ps    = (ps + pv) % 10;
            ddraw = bank_mask[ds][pv];
        end else begin
            ddraw = (ds <= 5);
        end
        if (pdraw) begin
            exp_v[exp_len++] = 8'h08;
            exp_v[exp_len++] = 8'h00;
        end
        if (ddraw) begin
            exp_v[exp_len++] = 8'h04;
            ds = (ds + cv(s.d3)) % 10;
        end
        exp_v[exp_len++] = {6'b0, ps >= ds, ds >= ps};
    endtask

    bit chk_en = 1'b0;
    int cnt [4];

    always @(negedge slow_clock) begin
        if (chk_en) begin
            int         i;
            logic [7:0] e;
            i = (n_edge < exp_len) ? n_edge : exp_len - 1;
            e = reset ? 8'h00 : exp_v[i];
            check("cycle_outputs", {24'b0, dut_v}, {24'b0, e});
            if (!reset) begin
                for (int j = 0; j < 4; j++) begin
                    if (dut_v[7-j]) cnt[j]++;
                end
            end
        end
    end

    task automatic run_scn(input int k);
        reset    = 1'b1;
        cur      = scn[k];
        scn_name = names[k];
        build(cur);
        chk_en   = 1'b1;
        @(negedge slow_clock);
        @(negedge slow_clock);
        reset = 1'b0;
        repeat (exp_len + 3) @(negedge slow_clock);
        #1;
        check("result_edge_model", exp_len - 1, cur.res_edge);
        check("final_lights", {30'b0, dut_v[1:0]}, {30'b0, cur.lights});
    endtask

    initial begin
        //              p1 p2 d1 d2 p3  d3 edge lights{P,D}
        scn[0]  = mk(3,  5,  1,  2,  9,  4, 6, 2'b10); names[0]  = "natural_p8_d3";
        scn[1]  = mk(2,  4, 13,  6,  9,  9, 6, 2'b11); names[1]  = "stand_tie_6";
        scn[2]  = mk(1,  3,  2,  1, 10,  5, 9, 2'b01); names[2]  = "both_draw_ten";
        scn[3]  = mk(1,  1, 12,  3,  8,  5, 8, 2'b01); names[3]  = "bank3_vs_8";
        scn[4]  = mk(10, 10, 3,  3,  7,  2, 9, 2'b01); names[4]  = "bank6_vs_7";
        scn[5]  = mk(10, 10, 3,  3,  5,  2, 8, 2'b01); names[5]  = "bank6_vs_5";
        scn[6]  = mk(3,  4,  2,  3,  9,  1, 7, 2'b10); names[6]  = "p7_bank5_draws";
        scn[7]  = mk(1,  1,  2,  2,  2,  4, 9, 2'b01); names[7]  = "bank4_vs_2";
        scn[8]  = mk(5, 10,  4,  1,  3,  9, 8, 2'b10); names[8]  = "bank5_vs_3";
        scn[9]  = mk(2,  2,  3,  4,  6,  9, 8, 2'b01); names[9]  = "bank7_stands";
        scn[10] = mk(1,  1,  4,  5,  9,  9, 6, 2'b01); names[10] = "dealer_natural_9";
        scn[11] = mk(1,  2, 10, 10,  8,  6, 9, 2'b01); names[11] = "bank0_vs_8";
        scn[12] = mk(3,  4,  2,  4,  9,  9, 6, 2'b10); names[12] = "stand_p7_d6";

        for (int k = 0; k < NSCN; k++) begin
            run_scn(k);
        end

        // Async reset in the middle of DEAL_P2, then a full restart.
        reset    = 1'b1;
        cur      = scn[2];
        scn_name = "reset_mid_p2";
        build(cur);
        @(negedge slow_clock);
        @(negedge slow_clock);
        reset = 1'b0;
        repeat (3) @(posedge slow_clock);
        #2;
        check("p2_strobe_before_reset", {24'b0, dut_v}, 32'h20);
        reset = 1'b1;
        #1;
        check("async_clear", {24'b0, dut_v}, 32'h00);
        @(negedge slow_clock);
        for (int j = 0; j < 4; j++) cnt[j] = 0;
        @(negedge slow_clock);
        reset = 1'b0;
        repeat (exp_len + 3) @(negedge slow_clock);
        #1;
        for (int j = 0; j < 4; j++) begin
            check("restart_strobe_count", cnt[j], 1);
        end
        check("restart_lights", {30'b0, dut_v[1:0]}, 32'h1);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
